// File: rtl/freqcnt_scan_if.sv
// Signal bundle between the scan controller (master) and its host / measurement core (slave).
// The timeout strobe exists only when FREQCNT_SCAN_TIMEOUT_EN is defined.
interface freqcnt_scan_if #(
  parameter int NCH = 4,
  parameter int CW  = 2
);
  logic           en;
  logic [NCH-1:0] ch_mask;
  logic [NCH-1:0] sig_in;
  logic           meas_in;
  logic           meas_start;
  logic           meas_done;
  logic [15:0]    meas_count;
  logic           meas_nosig;
  logic [CW-1:0]  cur_ch;
  logic           busy;
  logic           scan_done;
  logic [CW-1:0]  rd_ch;
  logic [15:0]    rd_count;
  logic           rd_nosig;
  logic           rd_valid;
`ifdef FREQCNT_SCAN_TIMEOUT_EN
  logic           timeout;
`endif

  modport master (
    input  en, ch_mask, sig_in, meas_done, meas_count, meas_nosig, rd_ch,
    output meas_in, meas_start, cur_ch, busy, scan_done, rd_count, rd_nosig, rd_valid
`ifdef FREQCNT_SCAN_TIMEOUT_EN
    , output timeout
`endif
  );

  modport slave (
    output en, ch_mask, sig_in, meas_done, meas_count, meas_nosig, rd_ch,
    input  meas_in, meas_start, cur_ch, busy, scan_done, rd_count, rd_nosig, rd_valid
`ifdef FREQCNT_SCAN_TIMEOUT_EN
    , input timeout
`endif
  );
endinterface

// File: rtl/freqcnt_scan_ctrl.sv
// Round-robin scheduler sharing one frequency-measurement core among NCH channels.
// Define FREQCNT_SCAN_TIMEOUT_EN to add a WAIT-state timeout (TIMEOUT cycles) and its strobe.
//
// state    | meaning
// IDLE     | scan disabled or mask empty
// SELECT   | pick next enabled channel, route it to meas_in
// SETTLE   | let the routed signal settle for SETTLE cycles
// START    | one-cycle meas_start pulse
// WAIT     | wait for meas_done (or timeout), capture result
// STORE    | write result registers, flag end of sweep
module freqcnt_scan_ctrl #(
  parameter int NCH    = 4,
  parameter int CW     = 2,
  parameter int SETTLE = 8
`ifdef FREQCNT_SCAN_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT = 16'hFFFF
`endif
) (
  input  logic           clk,
  input  logic           rst,
  freqcnt_scan_if.master bus
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT, S_STORE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic [SCW-1:0]  set_cnt_q, set_cnt_d;
  logic [15:0]     cap_cnt_q, cap_cnt_d;
  logic            cap_ns_q, cap_ns_d;
  logic            scan_done_q, scan_done_d;
  logic            wr_en;
  logic            meas_start;

  logic [15:0]     cnt_q [NCH];
  logic [NCH-1:0]  nosig_q, valid_q;
  logic [15:0]     rd_count_q;
  logic            rd_nosig_q, rd_valid_q;

  logic            hi_found, lo_found;
  logic [CW-1:0]   hi_ch, lo_ch, next_ch;

`ifdef FREQCNT_SCAN_TIMEOUT_EN
  logic [15:0]     to_cnt_q, to_cnt_d;
  logic            timeout;
`endif

  // Lowest enabled channel above cur_ch, else lowest at or below it (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = cur_ch_q;
    for (int j = 0; j < NCH; j++) begin
      if (bus.ch_mask[j] && (j > int'(cur_ch_q)) && !hi_found) begin
        hi_ch    = CW'(j);
        hi_found = 1'b1;
      end
      if (bus.ch_mask[j] && (j <= int'(cur_ch_q)) && !lo_found) begin
        lo_ch    = CW'(j);
        lo_found = 1'b1;
      end
    end
    next_ch = hi_found ? hi_ch : lo_ch;
  end

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    set_cnt_d   = set_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    cap_ns_d    = cap_ns_q;
    scan_done_d = 1'b0;
    wr_en       = 1'b0;
    meas_start  = 1'b0;
`ifdef FREQCNT_SCAN_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    timeout     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.en && (|bus.ch_mask)) state_d = S_SELECT;
      end
      S_SELECT: begin
        cur_ch_d  = next_ch;
        set_cnt_d = SCW'(SETTLE - 1);
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_cnt_q == '0) state_d = S_START;
        else                 set_cnt_d = set_cnt_q - 1'b1;
      end
      S_START: begin
        meas_start = 1'b1;
        state_d    = S_WAIT;
`ifdef FREQCNT_SCAN_TIMEOUT_EN
        to_cnt_d   = TIMEOUT - 16'd1;
`endif
      end
      S_WAIT: begin
        if (bus.meas_done) begin
          cap_cnt_d = bus.meas_count;
          cap_ns_d  = bus.meas_nosig;
          state_d   = S_STORE;
        end
`ifdef FREQCNT_SCAN_TIMEOUT_EN
        else if (to_cnt_q == '0) begin
          cap_cnt_d = '0;
          cap_ns_d  = 1'b1;
          timeout   = 1'b1;
          state_d   = S_STORE;
        end else begin
          to_cnt_d = to_cnt_q - 16'd1;
        end
`endif
      end
      S_STORE: begin
        wr_en       = 1'b1;
        scan_done_d = !hi_found;
        state_d     = (bus.en && (|bus.ch_mask)) ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_ch_q    <= CW'(NCH - 1);
      set_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      cap_ns_q    <= 1'b0;
      scan_done_q <= 1'b0;
`ifdef FREQCNT_SCAN_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      set_cnt_q   <= set_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_ns_q    <= cap_ns_d;
      scan_done_q <= scan_done_d;
`ifdef FREQCNT_SCAN_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Read port samples the pre-write contents, so a same-cycle write shows up one read later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      nosig_q    <= '0;
      valid_q    <= '0;
      rd_count_q <= '0;
      rd_nosig_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        cnt_q[cur_ch_q]   <= cap_cnt_q;
        nosig_q[cur_ch_q] <= cap_ns_q;
        valid_q[cur_ch_q] <= 1'b1;
      end
      if (int'(bus.rd_ch) < NCH) begin
        rd_count_q <= cnt_q[bus.rd_ch];
        rd_nosig_q <= nosig_q[bus.rd_ch];
        rd_valid_q <= valid_q[bus.rd_ch];
      end else begin
        rd_count_q <= '0;
        rd_nosig_q <= 1'b0;
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.meas_in    = bus.sig_in[cur_ch_q];
  assign bus.meas_start = meas_start;
  assign bus.cur_ch     = cur_ch_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.scan_done  = scan_done_q;
  assign bus.rd_count   = rd_count_q;
  assign bus.rd_nosig   = rd_nosig_q;
  assign bus.rd_valid   = rd_valid_q;
`ifdef FREQCNT_SCAN_TIMEOUT_EN
  assign bus.timeout    = timeout;
`endif

endmodule

// File: tb/tb_freqcnt_scan_ctrl.sv
// Scoreboard bench for freqcnt_scan_ctrl: tests queue expected starts, sweep ends and reads;
// a negedge monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_freqcnt_scan_ctrl;
  localparam int NCH = 4;
  localparam int CW = 2;
  localparam int SETTLE = 8;
  localparam int CORE_DLY = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  freqcnt_scan_if #(.NCH(NCH), .CW(CW)) bus ();

  freqcnt_scan_ctrl #(
    .NCH(NCH), .CW(CW), .SETTLE(SETTLE)
`ifdef FREQCNT_SCAN_TIMEOUT_EN
    , .TIMEOUT(16'd100)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [CW-1:0] ch; int cyc; } start_t;
  typedef struct { logic [15:0] cnt; logic ns; logic v; logic [CW-1:0] ch; } rd_t;

  start_t        exp_start_q[$];
  logic [CW-1:0] exp_scan_q[$];
  rd_t           exp_rd_q[$];
  start_t        st, ms;
  rd_t           mr;
  logic [CW-1:0] msc;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_starts = 0, n_scans = 0, n_tmo = 0;
  int en_cyc = 0, last_start_cyc = 0, tmo_cyc = 0, s0 = 0;

  logic          core_on = 1'b1;
  logic [15:0]   base = 16'h0000;
  logic          core_done = 1'b0, spur_done = 1'b0, core_ns = 1'b0;
  logic [15:0]   core_cnt = 16'h0000, spur_cnt = 16'h0000;
  logic [CW-1:0] core_ch;
  logic          rd_issue = 1'b0, rd_issue_d = 1'b0;

  assign bus.meas_done  = core_done | spur_done;
  assign bus.meas_count = core_done ? core_cnt : spur_cnt;
  assign bus.meas_nosig = core_done ? core_ns : 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rd_issue_d <= rd_issue;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Core model: answers CORE_DLY cycles after a start with base+ch; ch3 reports nosignal.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.meas_start === 1'b1 && core_on) begin
      core_ch = bus.cur_ch;
      repeat (CORE_DLY) @(negedge clk);
      if (!rst) begin
        core_done = 1'b1;
        core_cnt  = base + 16'(core_ch);
        core_ns   = (core_ch == 2'd3);
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.meas_start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
      if (exp_start_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL start_unexpected: got start on ch%0d want none (cycle %0d)", bus.cur_ch, cyc);
      end else begin
        ms = exp_start_q.pop_front();
        chk("start_ch", 32'(bus.cur_ch), 32'(ms.ch));
        if (ms.cyc >= 0) chk("start_cycle", cyc, ms.cyc);
      end
    end
    if (bus.scan_done === 1'b1) begin
      n_scans++;
      if (exp_scan_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scan_done_unexpected: got pulse at ch%0d want none (cycle %0d)", bus.cur_ch, cyc);
      end else begin
        msc = exp_scan_q.pop_front();
        chk("scan_done_ch", 32'(bus.cur_ch), 32'(msc));
      end
    end
    if (rd_issue_d && exp_rd_q.size() != 0) begin
      mr = exp_rd_q.pop_front();
      chk($sformatf("rd_count_ch%0d", mr.ch), 32'(bus.rd_count), 32'(mr.cnt));
      chk($sformatf("rd_nosig_ch%0d", mr.ch), 32'(bus.rd_nosig), 32'(mr.ns));
      chk($sformatf("rd_valid_ch%0d", mr.ch), 32'(bus.rd_valid), 32'(mr.v));
    end
`ifdef FREQCNT_SCAN_TIMEOUT_EN
    if (bus.timeout === 1'b1) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
`endif
  end

  task automatic push_start(input int ch, input int c);
    st.ch  = CW'(ch);
    st.cyc = c;
    exp_start_q.push_back(st);
  endtask

  task automatic do_read(input int ch, input logic [15:0] c, input logic ns, input logic v);
    rd_t e;
    e.cnt = c; e.ns = ns; e.v = v; e.ch = CW'(ch);
    @(negedge clk);
    bus.rd_ch = CW'(ch);
    exp_rd_q.push_back(e);
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic wait_starts(input int target, input string what);
    int k = 0;
    while (n_starts < target && k < 500) begin @(negedge clk); k++; end
    if (n_starts < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out with %0d starts want %0d", what, n_starts, target);
    end
  endtask

  task automatic wait_idle(input string what);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 500) begin @(negedge clk); k++; end
    if (bus.busy !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: busy stuck at %b want 0", what, bus.busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0;
    bus.ch_mask = '0;
    bus.sig_in = 4'b1000;
    bus.rd_ch = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cur_ch", 32'(bus.cur_ch), 32'd3);
    chk("rst_meas_start", 32'(bus.meas_start), 32'd0);
    chk("rst_scan_done", 32'(bus.scan_done), 32'd0);
    chk("rst_meas_in_ch3", 32'(bus.meas_in), 32'd1);
    do_read(2, 16'h0000, 1'b0, 1'b0);

    // Full mask sweep with timing: starts at en+10, then every 31 cycles.
    bus.ch_mask = 4'b1111;
    base = 16'h0100;
    @(negedge clk);
    bus.en = 1'b1;
    en_cyc = cyc;
    for (int k = 0; k < 4; k++) push_start(k, en_cyc + SETTLE + 2 + (CORE_DLY + SETTLE + 3) * k);
    exp_scan_q.push_back(2'd3);
    wait_starts(4, "sweep1_starts");
    bus.en = 1'b0;
    wait_idle("sweep1_idle");
    do_read(2, 16'h0102, 1'b0, 1'b1);
    do_read(3, 16'h0103, 1'b1, 1'b1);
    do_read(0, 16'h0100, 1'b0, 1'b1);

    // Sparse mask 1010 after a reset.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.ch_mask = 4'b1010;
    base = 16'h0200;
    s0 = n_starts;
    push_start(1, -1);
    push_start(3, -1);
    exp_scan_q.push_back(2'd3);
    bus.en = 1'b1;
    wait_starts(s0 + 2, "sparse_starts");
    bus.en = 1'b0;
    wait_idle("sparse_idle");
    do_read(0, 16'h0000, 1'b0, 1'b0);
    do_read(2, 16'h0000, 1'b0, 1'b0);
    do_read(1, 16'h0201, 1'b0, 1'b1);
    do_read(3, 16'h0203, 1'b1, 1'b1);

    // Drop en during WAIT on ch1; measurement completes, then resume at ch2.
    @(negedge clk);
    bus.ch_mask = 4'b1111;
    base = 16'h0300;
    s0 = n_starts;
    push_start(0, -1);
    push_start(1, -1);
    bus.en = 1'b1;
    wait_starts(s0 + 2, "endrop_starts");
    @(negedge clk);
    bus.en = 1'b0;
    wait_idle("endrop_idle");
    chk("endrop_cur_ch", 32'(bus.cur_ch), 32'd1);
    chk("endrop_meas_in_ch1", 32'(bus.meas_in), 32'd0);
    repeat (30) @(negedge clk);
    chk("endrop_no_more_starts", n_starts, s0 + 2);
    do_read(1, 16'h0301, 1'b0, 1'b1);
    push_start(2, -1);
    @(negedge clk);
    bus.en = 1'b1;
    wait_starts(s0 + 3, "resume_start");
    bus.en = 1'b0;
    wait_idle("resume_idle");
    do_read(2, 16'h0302, 1'b0, 1'b1);
    do_read(3, 16'h0203, 1'b1, 1'b1);

    // Spurious done pulses in SETTLE and START must not be stored.
    base = 16'h0400;
    s0 = n_starts;
    push_start(3, -1);
    exp_scan_q.push_back(2'd3);
    @(negedge clk);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    spur_cnt = 16'hDEAD;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    for (int k = 0; k < 100 && bus.meas_start !== 1'b1; k++) @(negedge clk);
    spur_cnt = 16'hBEEF;
    spur_done = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    spur_done = 1'b0;
    wait_idle("spur_idle");
    chk("spur_start_count", n_starts, s0 + 1);
    do_read(3, 16'h0403, 1'b1, 1'b1);

    // Reset during SETTLE on ch2.
    bus.ch_mask = 4'b0100;
    @(negedge clk);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_cur_ch", 32'(bus.cur_ch), 32'd2);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_cur_ch", 32'(bus.cur_ch), 32'd3);
    chk("post_rst_meas_start", 32'(bus.meas_start), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) do_read(k, 16'h0000, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

`ifdef FREQCNT_SCAN_TIMEOUT_EN
    // Core never answers: timeout after 100 WAIT cycles stores count 0 / nosig 1.
    core_on = 1'b0;
    bus.ch_mask = 4'b0001;
    s0 = n_starts;
    push_start(0, -1);
    exp_scan_q.push_back(2'd0);
    @(negedge clk);
    bus.en = 1'b1;
    wait_starts(s0 + 1, "tmo_start");
    bus.en = 1'b0;
    for (int k = 0; k < 300 && n_tmo == 0; k++) @(negedge clk);
    chk("tmo_pulses", n_tmo, 1);
    chk("tmo_cycle", tmo_cyc, last_start_cyc + 100);
    wait_idle("tmo_idle");
    do_read(0, 16'h0000, 1'b1, 1'b1);
    core_on = 1'b1;
`endif

    repeat (5) @(negedge clk);
    chk("start_queue_drained", exp_start_q.size(), 0);
    chk("scan_queue_drained", exp_scan_q.size(), 0);
    chk("read_queue_drained", exp_rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/freqcnt_scan_ctrl.md
Name: freqcnt_scan_ctrl

Overview:
Round-robin scheduler that shares one frequency-measurement core among NCH input signals. It selects a channel and routes that channel's signal to the core. It then waits a settle time, starts a measurement, waits for done and stores the 16-bit count and nosignal flag in per-channel result registers. A registered read port and an end-of-sweep pulse serve the host.

Parameters:
NCH, 4, number of input channels (2..16)
CW, 2, channel index width, must be >= clog2(NCH)
SETTLE, 8, cycles to wait after a mux switch before meas_start (>=1)
TIMEOUT, 16'hFFFF, WAIT-state cycle limit, used only with FREQCNT_SCAN_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  scan enable
ch_mask  in  NCH  per-channel enable; bit i=1 means channel i is scanned
sig_in  in  NCH  raw signals to be measured
meas_in  out  1  sig_in[cur_ch], combinational mux from the registered cur_ch
meas_start  out  1  one-cycle start pulse to the measurement core
meas_done  in  1  one-cycle done pulse from the core
meas_count  in  16  core result, valid with meas_done
meas_nosig  in  1  core nosignal flag, valid with meas_done
cur_ch  out  CW  channel currently routed to meas_in
busy  out  1  high in every state except IDLE
scan_done  out  1  one-cycle pulse after the highest-index enabled channel is stored
rd_ch  in  CW  result read address
rd_count  out  16  stored count of rd_ch, 1-cycle latency
rd_nosig  out  1  stored nosignal flag of rd_ch, 1-cycle latency
rd_valid  out  1  channel measured at least once since reset, 1-cycle latency

Behaviour:
- Reset values: state=IDLE, cur_ch=NCH-1 (so the first search starts at ch0), meas_start=0, scan_done=0, busy=0. All result counts=0, nosig=0, valid=0. rd_* outputs=0.
- Next-channel search: the first set ch_mask bit scanning upward from cur_ch+1, wrapping modulo NCH. The mask is sampled when the search is made. If the only set bit is cur_ch, the same channel is selected again.
- FSM states: IDLE, SELECT, SETTLE, START, WAIT, STORE.
- IDLE: if en=1 and ch_mask!=0, go to SELECT. Otherwise stay in IDLE.
- SELECT: cur_ch <= next channel. Clear the settle counter. Go to SETTLE.
- SETTLE: count SETTLE cycles, then go to START. meas_in is already switched in this state.
- START: meas_start=1 for exactly this cycle. Go to WAIT.
- WAIT: on meas_done=1, capture meas_count and meas_nosig and go to STORE. The done pulse is accepted from the first WAIT cycle onward.
- meas_done in any state other than WAIT is ignored.
- STORE: write cnt[cur_ch], nosig[cur_ch] and valid[cur_ch]<=1.
  - If no enabled channel has an index above cur_ch, scan_done=1 on the next cycle.
  - Then, if en=1 and ch_mask!=0, go to SELECT; otherwise go to IDLE.
- Timing: en rising in IDLE at cycle 0 gives SELECT at cycle 1 and meas_start at cycle SETTLE+2. After done, the next meas_start follows SETTLE+3 cycles later.
- en dropped mid-scan: the current measurement is completed and stored, then the FSM goes to IDLE. There is no abort. cur_ch is held, so re-enabling resumes round-robin order.
- ch_mask changed mid-measurement: the current channel finishes. The new mask applies at the next search.
- Read port: rd_* <= registers[rd_ch] every cycle. A read of the channel being written in STORE returns the old value; the new value appears on the following read cycle.
- rst mid-operation: immediate return to reset values on the clock edge. Stored results are lost.
- meas_count is stored verbatim, with no arithmetic on it.

Optional Feature:
FREQCNT_SCAN_TIMEOUT_EN.
- Defined: a 16-bit counter runs in WAIT. If it reaches TIMEOUT with no meas_done, the FSM goes to STORE with count=0 and nosig=1. A one-cycle timeout pulse output (1 bit) is also present.
- Undefined: WAIT waits indefinitely for done, and the timeout port does not exist.

Test Plan:
- Reset, then en=1, ch_mask=4'b1111, core model returns done 20 cycles after start with count=0x0100+ch. Expected: meas_start at cycle 10 after en; channels 0,1,2,3 visited in order; scan_done after ch3; rd_ch=2 gives rd_count=0x0102 and rd_valid=1.
- ch_mask=4'b1010 -> only channels 1 and 3 are visited; scan_done after ch3; rd_valid for ch0 and ch2 stays 0.
- en dropped while in WAIT on ch1 -> done is still stored for ch1, busy falls, no meas_start follows. Re-enable -> the next channel is ch2.
- Spurious meas_done pulses during SETTLE and START -> ignored; the stored value comes only from the done pulse in WAIT.
- rst pulsed during SETTLE on ch2 -> next cycle state=IDLE, cur_ch=3, all rd_valid=0, meas_start stays 0.
- With FREQCNT_SCAN_TIMEOUT_EN and TIMEOUT=100, the core never answers -> after 100 WAIT cycles the timeout output pulses, the stored count is 0 with nosig=1, and the scan advances.
